// File: rtl/aes128_pkg.sv
//==============================================================================
// Module : aes128_pkg
// Brief  : Shared AES-128 constants, FSM encoding and byte-level helper functions.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package aes128_pkg;

  localparam int NR_AES128 = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fsm_e;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'd10) begin
      return RCON[round];
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes128_enc_round.sv
//==============================================================================
// Module : aes128_enc_round (+ sub_bytes, shift_rows, mix_columns, add_round_key)
// Brief  : One AES encryption round; final_i bypasses MixColumns for the last round.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module aes128_sub_bytes
  import aes128_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign state_o[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
  end
endmodule

module aes128_shift_rows (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign state_o[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

module aes128_mix_columns
  import aes128_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = state_i[127-32*c -: 32];
    assign state_o[127-32*c -: 32] = {
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
    };
  end
endmodule

module aes128_add_round_key (
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  output logic [127:0] state_o
);
  assign state_o = state_i ^ rk_i;
endmodule

module aes128_enc_round (
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);
  logic [127:0] w_sb, w_sr, w_mc, w_mix_sel;

  aes128_sub_bytes   u_sub_bytes   (.state_i(state_i), .state_o(w_sb));
  aes128_shift_rows  u_shift_rows  (.state_i(w_sb),    .state_o(w_sr));
  aes128_mix_columns u_mix_columns (.state_i(w_sr),    .state_o(w_mc));

  assign w_mix_sel = final_i ? w_sr : w_mc;

  aes128_add_round_key u_add_round_key (.state_i(w_mix_sel), .rk_i(rk_i), .state_o(state_o));
endmodule

`default_nettype wire

// File: rtl/aes128_key_step.sv
//==============================================================================
// Module : aes128_key_step
// Brief  : One AES-128 key-schedule step: round key N and RCON in, round key N+1 out.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module aes128_key_step
  import aes128_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_o
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = rk_i;

  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_temp = {sbox(w_rot[31:24]) ^ rcon_i, sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]), sbox(w_rot[7:0])};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign rk_o = {w_n0, w_n1, w_n2, w_n3};

endmodule

`default_nettype wire

// File: rtl/aes128_round_sequencer.sv
//==============================================================================
// Module : aes128_round_sequencer
// Brief  : Iterative AES-128 encryptor, one round per clock, valid/ready on both sides.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module aes128_round_sequencer
  import aes128_pkg::*;
#(
  parameter int NR            = NR_AES128,
  parameter bit CLEAR_ON_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] ciphertext_o,
  output logic         busy_o
);

  localparam logic [3:0] LAST_MIX_ROUND = 4'(NR - 1);

  fsm_e         fsm_q;
  logic [127:0] state_q, rk_q;
  logic [3:0]   round_cnt_q;
  logic         in_ready_q, out_valid_q, busy_q;

  logic [127:0] rk_d, state_d;
  logic [7:0]   w_rcon;
  logic         w_final;

  assign w_rcon  = rcon_of(round_cnt_q);
  assign w_final = (fsm_q == ST_FINAL);

  aes128_key_step u_key_step (
    .rk_i   (rk_q),
    .rcon_i (w_rcon),
    .rk_o   (rk_d)
  );

  aes128_enc_round u_enc_round (
    .state_i (state_q),
    .rk_i    (rk_d),
    .final_i (w_final),
    .state_o (state_d)
  );

  // in_ready is registered so it only rises on the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      round_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            state_q     <= plaintext_i ^ key_i;
            rk_q        <= key_i;
            round_cnt_q <= 4'd1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            fsm_q       <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_q     <= state_d;
          rk_q        <= rk_d;
          round_cnt_q <= round_cnt_q + 4'd1;
          if (round_cnt_q == LAST_MIX_ROUND) begin
            fsm_q <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          state_q     <= state_d;
          rk_q        <= rk_d;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          fsm_q       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            round_cnt_q <= '0;
            fsm_q       <= ST_IDLE;
            if (CLEAR_ON_IDLE) begin
              state_q <= '0;
              rk_q    <= '0;
            end
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = busy_q;
  assign ciphertext_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_aes128_round_sequencer.sv
//==============================================================================
// Module : tb_aes128_round_sequencer
// Brief  : Directed FIPS-197 vectors, latency, backpressure, back-to-back and reset cases.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_aes128_round_sequencer;

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  aes128_round_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .plaintext_i  (plaintext),
    .key_i        (key),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .ciphertext_o (ciphertext),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic offer(input logic [127:0] pt, input logic [127:0] k, output int acc);
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    acc       = cyc;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    at = cyc;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    repeat (2) step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (ciphertext !== 128'h0) begin failures++; $display("FAIL rst_ct got=%h exp=0", ciphertext); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_fips_b();
    int acc, at;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b_in_ready got=%b exp=1", in_ready); end
    offer(PT1, KEY1, acc);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b_busy got=%b exp=1", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b_in_ready_busy got=%b exp=0", in_ready); end
    wait_valid(at);
    checks++; if (at - acc !== 11) begin failures++; $display("FAIL b_latency got=%0d exp=11", at - acc); end
    checks++; if (ciphertext !== CT1) begin failures++; $display("FAIL b_ct got=%h exp=%h", ciphertext, CT1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b_busy_done got=%b exp=0", busy); end
    drain();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b_out_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b_in_ready_idle got=%b exp=1", in_ready); end
    checks++; if (ciphertext !== 128'h0) begin failures++; $display("FAIL b_clear got=%h exp=0", ciphertext); end
  endtask

  task automatic test_fips_c1();
    int acc, at;
    offer(PT2, KEY2, acc);
    wait_valid(at);
    checks++; if (at - acc !== 11) begin failures++; $display("FAIL c1_latency got=%0d exp=11", at - acc); end
    checks++; if (ciphertext !== CT2) begin failures++; $display("FAIL c1_ct got=%h exp=%h", ciphertext, CT2); end
    drain();
  endtask

  task automatic test_backpressure();
    int acc, at;
    bit bad = 1'b0;
    offer(PT1, KEY1, acc);
    wait_valid(at);
    repeat (20) begin
      step();
      if (ciphertext !== CT1 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b exp=0 (ct=%h)", bad, ciphertext); end
    drain();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc;
    int nrec = 0;
    int t [2] = '{0, 0};
    logic [127:0] c [2] = '{128'h0, 128'h0};
    plaintext = PT1; key = KEY1; in_valid = 1'b1; out_ready = 1'b1;
    acc = cyc;
    step();
    plaintext = PT2; key = KEY2;
    for (int i = 0; i < 40 && nrec < 2; i++) begin
      if (out_valid === 1'b1) begin
        t[nrec] = cyc;
        c[nrec] = ciphertext;
        nrec++;
        if (nrec == 2) in_valid = 1'b0;
      end
      step();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (nrec !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", nrec); end
    checks++; if (t[0] - acc !== 11) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=11", t[0] - acc); end
    checks++; if (t[1] - t[0] !== 12) begin failures++; $display("FAIL b2b_spacing got=%0d exp=12", t[1] - t[0]); end
    checks++; if (c[0] !== CT1) begin failures++; $display("FAIL b2b_ct1 got=%h exp=%h", c[0], CT1); end
    checks++; if (c[1] !== CT2) begin failures++; $display("FAIL b2b_ct2 got=%h exp=%h", c[1], CT2); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b%b exp=10", in_ready, busy); end
  endtask

  task automatic test_reset_midop();
    int acc, at;
    offer(PT1, KEY1, acc);
    repeat (4) step();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_outputs got=%b%b exp=00", out_valid, busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (ciphertext !== 128'h0) begin failures++; $display("FAIL mid_rst_ct got=%h exp=0", ciphertext); end
    step();
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_recover got=%b exp=1", in_ready); end
    offer(PT2, KEY2, acc);
    wait_valid(at);
    checks++; if (at - acc !== 11) begin failures++; $display("FAIL mid_rerun_lat got=%0d exp=11", at - acc); end
    checks++; if (ciphertext !== CT2) begin failures++; $display("FAIL mid_rerun_ct got=%h exp=%h", ciphertext, CT2); end
    drain();
  endtask

  task automatic test_input_change();
    int acc, at;
    offer(PT2, KEY2, acc);
    for (int i = 2; i <= 9; i++) begin
      step();
      in_valid  = 1'b1;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = (i % 2 == 0) ? KEY1 : {$urandom, $urandom, $urandom, $urandom};
    end
    step();
    in_valid = 1'b0;
    wait_valid(at);
    checks++; if (at - acc !== 11) begin failures++; $display("FAIL chg_latency got=%0d exp=11", at - acc); end
    checks++; if (ciphertext !== CT2) begin failures++; $display("FAIL chg_ct got=%h exp=%h", ciphertext, CT2); end
    drain();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL chg_idle got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_input_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
